// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD refresh sequencer:
// command bytes, sequencer/transfer state encodings and frame byte lookup.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE0    = 8'h80;
  localparam logic [7:0] LCD_LINE1    = 8'hC0;

  localparam int N_INIT    = 4;
  localparam int N_REFRESH = 34;

  typedef enum logic [1:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    REFRESH
  } top_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_WAIT
  } phase_e;

  // Character n (0..31) of the frame; character 0 is the top byte.
  // 31-n is the bitwise inverse of n for a 5-bit index.
  function automatic logic [7:0] frame_byte(input logic [255:0] frame, input logic [4:0] n);
    logic [4:0] m;
    m = ~n;
    return frame[{m, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus transfer: SETUP (rs/data driven, e low), STROBE (e high), WAIT.
// A new request is accepted while idle or on the last WAIT cycle, so transfers chain gaplessly.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = 4,
  parameter int T_E_HIGH     = 50,
  parameter int T_CMD_WAIT   = 10_000,
  parameter int T_CLEAR_WAIT = 400_000,
  parameter int CNT_W        = 19
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] tx_byte,
  input  logic       long_wait,
  output logic       ready,
  output logic       ack,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR_WAIT - 1);

  phase_e           phase;
  logic [CNT_W-1:0] cnt;
  logic             long_q;

  assign ack   = (phase == PH_WAIT) && (cnt == '0);
  assign ready = (phase == PH_IDLE) || ack;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
    end else if (req && ready) begin
      phase    <= PH_SETUP;
      cnt      <= SETUP_LD;
      long_q   <= long_wait;
      lcd_data <= tx_byte;
      lcd_rs   <= rs;
      lcd_e    <= 1'b0;
    end else begin
      case (phase)
        PH_SETUP: begin
          if (cnt == '0) begin
            phase <= PH_STROBE;
            cnt   <= EHIGH_LD;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_STROBE: begin
          if (cnt == '0) begin
            phase <= PH_WAIT;
            cnt   <= long_q ? CLEAR_LD : CMD_LD;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_WAIT: begin
          if (cnt == '0) begin
            phase <= PH_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          phase <= PH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_seq.sv
// Owns the character-LCD bus: power-up delay, init commands, then on each start
// writes a snapshot of the 32-character frame (address, 16 bytes, address, 16 bytes).
module lcd_refresh_seq
  import lcd_pkg::*;
#(
  parameter int P_POWERUP    = 1_500_000,
  parameter int T_SETUP      = 4,
  parameter int T_E_HIGH     = 50,
  parameter int T_CMD_WAIT   = 10_000,
  parameter int T_CLEAR_WAIT = 400_000
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [255:0] line_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [7:0]   lcd_data,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw
);

  localparam int CNT_MAX = (P_POWERUP > T_CLEAR_WAIT) ? P_POWERUP : T_CLEAR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(P_POWERUP - 1);

  top_state_e       state;
  logic [CNT_W-1:0] pwr_cnt;
  logic [5:0]       idx;
  logic [255:0]     snap;

  logic       wr_req;
  logic       wr_rs;
  logic [7:0] wr_byte;
  logic       wr_long;
  logic       wr_ready;
  logic       wr_ack;

  assign lcd_rw = 1'b0;

  // idx is the next transfer to hand to the writer; 33 needs six bits.
  always_comb begin
    wr_req  = 1'b0;
    wr_rs   = 1'b0;
    wr_byte = 8'h00;
    wr_long = 1'b0;
    case (state)
      INIT: begin
        wr_req = idx < 6'(N_INIT);
        case (idx[1:0])
          2'd0:    wr_byte = LCD_FUNC_SET;
          2'd1:    wr_byte = LCD_DISP_ON;
          2'd2:    wr_byte = LCD_ENTRY;
          default: wr_byte = LCD_CLEAR;
        endcase
        wr_long = (idx[1:0] == 2'd3);
      end
      REFRESH: begin
        wr_req = idx < 6'(N_REFRESH);
        if (idx == 6'd0) begin
          wr_byte = LCD_LINE0;
        end else if (idx < 6'd17) begin
          wr_rs   = 1'b1;
          wr_byte = frame_byte(snap, 5'(idx - 6'd1));
        end else if (idx == 6'd17) begin
          wr_byte = LCD_LINE1;
        end else begin
          wr_rs   = 1'b1;
          wr_byte = frame_byte(snap, 5'(idx - 6'd2));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= PWR_WAIT;
      pwr_cnt <= '0;
      idx     <= '0;
      snap    <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_req && wr_ready) begin
        idx <= idx + 6'd1;
      end
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == PWR_LAST) begin
            state <= INIT;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        INIT: begin
          if (wr_ack && idx == 6'(N_INIT)) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end
        end
        IDLE: begin
          if (start) begin
            snap  <= line_data;
            busy  <= 1'b1;
            idx   <= '0;
            state <= REFRESH;
          end
        end
        REFRESH: begin
          if (wr_ack && idx == 6'(N_REFRESH)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_byte_writer #(
    .T_SETUP      (T_SETUP),
    .T_E_HIGH     (T_E_HIGH),
    .T_CMD_WAIT   (T_CMD_WAIT),
    .T_CLEAR_WAIT (T_CLEAR_WAIT),
    .CNT_W        (CNT_W)
  ) u_writer (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (wr_req),
    .rs        (wr_rs),
    .tx_byte   (wr_byte),
    .long_wait (wr_long),
    .ready     (wr_ready),
    .ack       (wr_ack),
    .lcd_data  (lcd_data),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs)
  );

endmodule

// File: tb/tb_lcd_refresh_seq.sv
// Self-checking bench for lcd_refresh_seq: a bus monitor captures every E pulse and
// its timing, and each scenario compares the captured stream against a frame model.
module tb_lcd_refresh_seq;

  localparam int P  = 20;
  localparam int S  = 2;
  localparam int EH = 4;
  localparam int CW = 10;
  localparam int CL = 50;
  localparam int INIT_LEN = P + 3 * (S + EH + CW) + (S + EH + CL);
  localparam int REF_LEN  = 1 + 34 * (S + EH + CW);

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [255:0] line_data = '0;
  logic         start = 1'b0;
  logic         busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]   lcd_data;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_refresh_seq #(
    .P_POWERUP(P), .T_SETUP(S), .T_E_HIGH(EH), .T_CMD_WAIT(CW), .T_CLEAR_WAIT(CL)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .line_data(line_data), .start(start),
    .busy(busy), .done(done), .lcd_data(lcd_data), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 sys_clk = ~sys_clk;

  // Bus monitor, sampled on the falling edge.
  logic [7:0] cap_d[$];
  logic       cap_rs[$];
  logic [7:0] exp_d[$];
  logic       exp_rs[$];
  logic       mon_skip = 1'b1;
  int stab_err = 0, width_err = 0, rw_err = 0, done_cnt = 0;
  logic       e_q = 1'b0, rs_h1 = 1'b0, rs_h2 = 1'b0, p_rs = 1'b0;
  logic [7:0] d_h1 = 8'h00, d_h2 = 8'h00, p_d = 8'h00;
  int hi_cnt = 0, post_cnt = 0;

  always @(negedge sys_clk) begin
    if (!mon_skip && lcd_rw !== 1'b0) rw_err++;
    if (done === 1'b1) done_cnt++;
    if (lcd_e === 1'b1 && !e_q) begin
      cap_d.push_back(lcd_data);
      cap_rs.push_back(lcd_rs);
      if (!mon_skip && (d_h1 !== lcd_data || d_h2 !== lcd_data ||
                        rs_h1 !== lcd_rs || rs_h2 !== lcd_rs)) stab_err++;
      p_d = lcd_data; p_rs = lcd_rs; hi_cnt = 1; post_cnt = 0;
    end else if (lcd_e === 1'b1) begin
      hi_cnt++;
      if (!mon_skip && (lcd_data !== p_d || lcd_rs !== p_rs)) stab_err++;
    end else if (e_q) begin
      if (!mon_skip && hi_cnt != EH) width_err++;
      post_cnt = CW;
    end
    if (lcd_e !== 1'b1 && post_cnt > 0) begin
      if (!mon_skip && (lcd_data !== p_d || lcd_rs !== p_rs)) stab_err++;
      post_cnt--;
    end
    d_h2 = d_h1; d_h1 = lcd_data; rs_h2 = rs_h1; rs_h1 = lcd_rs;
    e_q = (lcd_e === 1'b1);
    if (mon_skip) begin hi_cnt = 0; post_cnt = 0; end
  end

  // Reference stream: line address, 16 characters, line address, 16 characters.
  function automatic void build_exp(input logic [255:0] f);
    exp_d.delete(); exp_rs.delete();
    exp_d.push_back(8'h80); exp_rs.push_back(1'b0);
    for (int i = 0; i < 16; i++) begin exp_d.push_back(f[255 - 8*i -: 8]); exp_rs.push_back(1'b1); end
    exp_d.push_back(8'hC0); exp_rs.push_back(1'b0);
    for (int i = 0; i < 16; i++) begin exp_d.push_back(f[127 - 8*i -: 8]); exp_rs.push_back(1'b1); end
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
    n_checks++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
    n_checks++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
    n_checks++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
  endtask

  // Init after release, with a start pulse thrown in that must be ignored.
  task automatic test_init();
    logic [7:0] init_b[4];
    int found, sp;
    init_b = '{8'h38, 8'h0C, 8'h06, 8'h01};
    sp = $urandom_range(5, 110);
    cap_d.delete(); cap_rs.delete();
    sys_rst = 1'b0;
    @(posedge sys_clk);
    found = -1;
    for (int k = 0; k <= 400 && found < 0; k++) begin
      @(negedge sys_clk);
      if (k == 0) mon_skip = 1'b0;
      if (busy === 1'b0) found = k;
      start = (k == sp);
    end
    start = 1'b0;
    n_checks++; if (found != INIT_LEN) begin n_fail++; $display("FAIL init_busy_fall: got %0d expected %0d", found, INIT_LEN); end
    repeat (30) @(negedge sys_clk);
    n_checks++; if (cap_d.size() != 4) begin n_fail++; $display("FAIL init_pulse_count: got %0d expected 4", cap_d.size()); end
    for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== init_b[i] || cap_rs[i] !== 1'b0) begin
        n_fail++; $display("FAIL init_byte%0d: got %h rs=%b expected %h rs=0", i, cap_d[i], cap_rs[i], init_b[i]);
      end
    end
  endtask

  task automatic test_refresh_text();
    logic [255:0] f;
    int found;
    f = {"Firmware loaded!", "0123456789abcdef"};
    build_exp(f);
    cap_d.delete(); cap_rs.delete();
    line_data = f; start = 1'b1;
    @(posedge sys_clk);
    found = -1;
    for (int k = 0; k <= 1200 && found < 0; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (done === 1'b1) found = k;
    end
    n_checks++; if (found != REF_LEN) begin n_fail++; $display("FAIL text_done_time: got %0d expected %0d", found, REF_LEN); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL text_busy_at_done: got %b expected 0", busy); end
    @(negedge sys_clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL text_done_width: got %b expected 0", done); end
    n_checks++; if (lcd_data !== 8'h66 || lcd_rs !== 1'b1) begin
      n_fail++; $display("FAIL text_idle_hold: got %h rs=%b expected 66 rs=1", lcd_data, lcd_rs);
    end
    n_checks++; if (cap_d.size() != 34) begin n_fail++; $display("FAIL text_pulse_count: got %0d expected 34", cap_d.size()); end
    for (int i = 0; i < 34 && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp_d[i] || cap_rs[i] !== exp_rs[i]) begin
        n_fail++; $display("FAIL text_byte%0d: got %h rs=%b expected %h rs=%b", i, cap_d[i], cap_rs[i], exp_d[i], exp_rs[i]);
      end
    end
  endtask

  task automatic test_pulse_timing();
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL pulse_stability: got %0d violations expected 0", stab_err); end
    n_checks++; if (width_err != 0) begin n_fail++; $display("FAIL pulse_width: got %0d violations expected 0", width_err); end
    n_checks++; if (rw_err != 0) begin n_fail++; $display("FAIL rw_low: got %0d violations expected 0", rw_err); end
  endtask

  task automatic test_ignore_start();
    logic [255:0] f;
    int found, mid;
    f = rand_frame();
    build_exp(f);
    mid = $urandom_range(50, 400);
    cap_d.delete(); cap_rs.delete();
    line_data = f; start = 1'b1;
    @(posedge sys_clk);
    found = -1;
    for (int k = 0; k <= 1200 && found < 0; k++) begin
      @(negedge sys_clk);
      start = (k == mid);
      if (k == mid) line_data = rand_frame();
      if (done === 1'b1) found = k;
    end
    start = 1'b0;
    n_checks++; if (found != REF_LEN) begin n_fail++; $display("FAIL ignore_done_time: got %0d expected %0d", found, REF_LEN); end
    repeat (30) @(negedge sys_clk);
    n_checks++; if (cap_d.size() != 34) begin n_fail++; $display("FAIL ignore_pulse_count: got %0d expected 34", cap_d.size()); end
    for (int i = 0; i < 34 && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp_d[i] || cap_rs[i] !== exp_rs[i]) begin
        n_fail++; $display("FAIL ignore_byte%0d: got %h rs=%b expected %h rs=%b", i, cap_d[i], cap_rs[i], exp_d[i], exp_rs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] init_b[4];
    int found, done_before, t;
    init_b = '{8'h38, 8'h0C, 8'h06, 8'h01};
    cap_d.delete(); cap_rs.delete();
    line_data = rand_frame(); start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    t = 0;
    while (!(cap_d.size() >= 11 && lcd_e === 1'b1) && t < 1000) begin @(negedge sys_clk); t++; end
    n_checks++; if (t >= 1000) begin n_fail++; $display("FAIL midrst_reach_byte10: got timeout expected E high at byte 10"); end
    done_before = done_cnt;
    mon_skip = 1'b1; sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL midrst_e_drop: got %b expected 0", lcd_e); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    sys_rst = 1'b0;
    cap_d.delete(); cap_rs.delete();
    @(posedge sys_clk);
    found = -1;
    for (int k = 0; k <= 400 && found < 0; k++) begin
      @(negedge sys_clk);
      if (k == 0) mon_skip = 1'b0;
      if (busy === 1'b0) found = k;
    end
    n_checks++; if (found != INIT_LEN) begin n_fail++; $display("FAIL midrst_init_time: got %0d expected %0d", found, INIT_LEN); end
    repeat (10) @(negedge sys_clk);
    n_checks++; if (cap_d.size() != 4) begin n_fail++; $display("FAIL midrst_pulse_count: got %0d expected 4", cap_d.size()); end
    for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== init_b[i] || cap_rs[i] !== 1'b0) begin
        n_fail++; $display("FAIL midrst_byte%0d: got %h rs=%b expected %h rs=0", i, cap_d[i], cap_rs[i], init_b[i]);
      end
    end
    n_checks++; if (done_cnt != done_before) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected %0d", done_cnt, done_before); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] fa, fb;
    int found;
    fa = rand_frame(); fa[7:0] = 8'h55;
    fb = rand_frame();
    line_data = fa; start = 1'b1;
    @(posedge sys_clk);
    found = -1;
    for (int k = 0; k <= 1200 && found < 0; k++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (done === 1'b1) found = k;
    end
    n_checks++; if (found != REF_LEN) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", found, REF_LEN); end
    // Same sample that shows busy low: request the next frame.
    cap_d.delete(); cap_rs.delete();
    build_exp(fb);
    line_data = fb; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || lcd_data !== 8'h55) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b data=%h expected busy=1 data=55", busy, lcd_data);
    end
    @(negedge sys_clk);
    n_checks++; if (lcd_data !== 8'h80 || lcd_rs !== 1'b0 || lcd_e !== 1'b0) begin
      n_fail++; $display("FAIL b2b_setup: got data=%h rs=%b e=%b expected 80 0 0", lcd_data, lcd_rs, lcd_e);
    end
    found = -1;
    for (int k = 2; k <= 1200 && found < 0; k++) begin
      @(negedge sys_clk);
      if (done === 1'b1) found = k;
    end
    n_checks++; if (found != REF_LEN) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", found, REF_LEN); end
    n_checks++; if (cap_d.size() != 34) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 34", cap_d.size()); end
    for (int i = 0; i < 34 && i < cap_d.size(); i++) begin
      n_checks++;
      if (cap_d[i] !== exp_d[i] || cap_rs[i] !== exp_rs[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h rs=%b expected %h rs=%b", i, cap_d[i], cap_rs[i], exp_d[i], exp_rs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_text();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_pulse_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
